program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, instruction word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 11, per-bank word address width (DEPTH = 2**ADDRESS_WIDTH).
REQ-003 SHALL have parameter NUM_BANKS, default 2, program bank count, legal 2..8; BANK_WIDTH = $clog2(NUM_BANKS).
REQ-004 SHALL have parameter TERMINATOR, default all-zeros, end-of-program word value.
REQ-005 clock_in  input  1  single clock, rising edge; one clock, reset asynchronous active-low.
REQ-006 reset_n_in  input  1  asynchronous active-low reset.
REQ-007 ready_in  input  1  one-cycle strobe, instruction_in valid.
REQ-008 instruction_in  input  DATA_WIDTH  incoming instruction word.
REQ-009 bank_release_in  input  1  one-cycle strobe, consumer finished with active bank.
REQ-010 memory_wr_out  output  1  one-cycle memory write enable.
REQ-011 memory_bank_out  output  BANK_WIDTH  bank being written.
REQ-012 memory_address_out  output  ADDRESS_WIDTH  word address being written.
REQ-013 instruction_out  output  DATA_WIDTH  word being written.
REQ-014 active_bank_out  output  BANK_WIDTH  oldest committed bank, for the consumer.
REQ-015 active_length_out  output  ADDRESS_WIDTH+1  word count of active bank, terminator included.
REQ-016 program_valid_out  output  1  at least one committed bank.
REQ-017 busy_out  output  1  program partially loaded.
REQ-018 drop_out  output  1  one-cycle pulse, word discarded (all banks full).
REQ-019 overflow_out  output  1  one-cycle pulse, bank filled without terminator.

Function
REQ-020 SHALL sample ready_in/instruction_in on rising clock_in; accepted word appears on memory_* outputs the next cycle (latency 1), memory_wr_out high exactly one cycle per word.
REQ-021 SHALL use FSM states IDLE, LOAD, FULL: IDLE->LOAD on accepted non-terminator word; LOAD->IDLE on commit with a free bank remaining; IDLE/LOAD->FULL on commit leaving zero free banks; FULL->IDLE on bank_release_in.
REQ-022 SHALL write words to consecutive addresses from 0 in the write bank; write pointer increments once per accepted word.
REQ-023 SHALL write the TERMINATOR word itself, then commit: store length = pointer+1 for that bank, advance write bank modulo NUM_BANKS, reset pointer to 0.
REQ-024 A TERMINATOR in IDLE SHALL commit a length-1 program.
REQ-025 When a non-terminator word is written at address DEPTH-1, SHALL commit with length DEPTH and pulse overflow_out in the write cycle.
REQ-026 In FULL, ready_in words SHALL NOT be written; drop_out pulses one cycle later per dropped word.
REQ-027 bank_release_in with program_valid_out=1 SHALL advance active bank modulo NUM_BANKS and decrement committed count; with program_valid_out=0 SHALL be ignored.
REQ-028 Commit and release in the same cycle SHALL both take effect; committed count unchanged, state not FULL.
REQ-029 Release and ready_in in the same cycle in FULL SHALL drop that word (release visible next cycle).
REQ-030 program_valid_out = committed count > 0; busy_out = state LOAD; active_length_out = stored length of active bank, registered.
REQ-031 Committed count width SHALL hold 0..NUM_BANKS inclusive, no wrap.

Reset
REQ-032 On reset_n_in low, asynchronously: state IDLE, pointers, bank indices, count, lengths 0; all outputs 0.
REQ-033 Reset mid-load SHALL discard the partial program; no memory_wr_out after reset assertion.

Structure
REQ-034 Package program_loader_pkg SHALL hold the state enum and the default TERMINATOR constant.
REQ-035 Sub-module bank_ring (write index, read index, committed count, full/empty) SHALL be instantiated once.

Verification
REQ-036 Words 0x0004,0x0003,0x0000 -> writes bank 0 addr 0,1,2; program_valid_out=1, active_bank_out=0, active_length_out=3.
REQ-037 Second program 0x000A..0x000F,0x0000 with bank 0 unreleased -> bank 1 addr 0..6, then state FULL; next word -> drop_out pulse, no write.
REQ-038 Release and terminator commit same cycle -> count unchanged, active_bank_out advances, no drop.
REQ-039 ADDRESS_WIDTH=3, nine 0x0001 words -> 8 writes, overflow_out at addr 7, length 8, ninth word goes to next bank addr 0.
REQ-040 Reset asserted after two words of a program -> all outputs 0 immediately; next program starts bank 0 addr 0.
REQ-041 NUM_BANKS=3, four single-terminator programs with one release -> bank indices wrap 0,1,2,0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM encoding and default end-of-program word.
package program_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [63:0] TERMINATOR_DEFAULT = 64'h0;

endpackage

// File: rtl/bank_ring.sv
// Ring of program banks: write index, read (active) index and committed-program count.
module bank_ring #(
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned BANK_WIDTH  = 1,
  parameter int unsigned COUNT_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   commit,
  input  logic                   release_req,
  output logic [BANK_WIDTH-1:0]  wr_bank,
  output logic [BANK_WIDTH-1:0]  rd_bank,
  output logic [BANK_WIDTH-1:0]  rd_next_c,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   release_eff_c
);

  function automatic logic [BANK_WIDTH-1:0] next_index(input logic [BANK_WIDTH-1:0] idx);
    return (idx == BANK_WIDTH'(NUM_BANKS - 1)) ? '0 : idx + BANK_WIDTH'(1);
  endfunction

  // A release with nothing committed is ignored.
  always_comb begin
    empty         = (count == '0);
    full          = (count == COUNT_WIDTH'(NUM_BANKS));
    release_eff_c = release_req && !empty;
    rd_next_c     = release_eff_c ? next_index(rd_bank) : rd_bank;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= '0;
      rd_bank <= '0;
      count   <= '0;
    end else begin
      if (commit) wr_bank <= next_index(wr_bank);
      rd_bank <= rd_next_c;
      case ({commit, release_eff_c})
        2'b10:   count <= count + COUNT_WIDTH'(1);
        2'b01:   count <= count - COUNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams instruction words into a ring of program banks, committing a bank on terminator or when it fills.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 11,
  parameter int unsigned NUM_BANKS     = 2,
  parameter logic [DATA_WIDTH-1:0] TERMINATOR = DATA_WIDTH'(TERMINATOR_DEFAULT),
  localparam int unsigned BANK_WIDTH   = $clog2(NUM_BANKS)
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic                     ready_in,
  input  logic [DATA_WIDTH-1:0]    instruction_in,
  input  logic                     bank_release_in,
  output logic                     memory_wr_out,
  output logic [BANK_WIDTH-1:0]    memory_bank_out,
  output logic [ADDRESS_WIDTH-1:0] memory_address_out,
  output logic [DATA_WIDTH-1:0]    instruction_out,
  output logic [BANK_WIDTH-1:0]    active_bank_out,
  output logic [ADDRESS_WIDTH:0]   active_length_out,
  output logic                     program_valid_out,
  output logic                     busy_out,
  output logic                     drop_out,
  output logic                     overflow_out
);

  localparam int unsigned DEPTH       = 1 << ADDRESS_WIDTH;
  localparam int unsigned LEN_WIDTH   = ADDRESS_WIDTH + 1;
  localparam int unsigned COUNT_WIDTH = $clog2(NUM_BANKS + 1);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q;
  logic [LEN_WIDTH-1:0]     lengths_q [NUM_BANKS];
  logic [LEN_WIDTH-1:0]     len_new, active_len_d;
  logic                     accept, commit, overflow_c, drop_c, is_term, last_addr, fills;

  logic [BANK_WIDTH-1:0]    wr_bank, rd_bank, rd_next_c;
  logic [COUNT_WIDTH-1:0]   count;
  logic                     full, empty, release_eff_c;

  bank_ring #(
    .NUM_BANKS  (NUM_BANKS),
    .BANK_WIDTH (BANK_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_ring (
    .clk          (clock_in),
    .rst_n        (reset_n_in),
    .commit       (commit),
    .release_req  (bank_release_in),
    .wr_bank      (wr_bank),
    .rd_bank      (rd_bank),
    .rd_next_c    (rd_next_c),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .release_eff_c(release_eff_c)
  );

  // Next state and per-word control; a commit fills the ring only if no release lands alongside it.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    commit       = 1'b0;
    overflow_c   = 1'b0;
    drop_c       = 1'b0;
    is_term      = (instruction_in == TERMINATOR);
    last_addr    = (ptr_q == ADDRESS_WIDTH'(DEPTH - 1));
    fills        = (count == COUNT_WIDTH'(NUM_BANKS - 1)) && !release_eff_c;
    len_new      = {1'b0, ptr_q} + LEN_WIDTH'(1);

    if (ready_in) begin
      if ((state_q == FULL) || full) begin
        drop_c = 1'b1;
      end else begin
        accept     = 1'b1;
        commit     = is_term || last_addr;
        overflow_c = !is_term && last_addr;
      end
    end

    case (state_q)
      IDLE, LOAD: begin
        if (commit)      state_d = fills ? FULL : IDLE;
        else if (accept) state_d = LOAD;
      end
      FULL:    if (release_eff_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    active_len_d = (commit && (wr_bank == rd_next_c)) ? len_new : lengths_q[rd_next_c];
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q            <= IDLE;
      ptr_q              <= '0;
      for (int i = 0; i < int'(NUM_BANKS); i++) lengths_q[i] <= '0;
      memory_wr_out      <= 1'b0;
      memory_bank_out    <= '0;
      memory_address_out <= '0;
      instruction_out    <= '0;
      active_length_out  <= '0;
      drop_out           <= 1'b0;
      overflow_out       <= 1'b0;
    end else begin
      state_q       <= state_d;
      memory_wr_out <= accept;
      drop_out      <= drop_c;
      overflow_out  <= overflow_c;
      if (accept) begin
        memory_bank_out    <= wr_bank;
        memory_address_out <= ptr_q;
        instruction_out    <= instruction_in;
      end
      if (commit)      ptr_q <= '0;
      else if (accept) ptr_q <= ptr_q + ADDRESS_WIDTH'(1);
      if (commit) lengths_q[wr_bank] <= len_new;
      active_length_out <= active_len_d;
    end
  end

  assign active_bank_out   = rd_bank;
  assign program_valid_out = !empty;
  assign busy_out          = (state_q == LOAD);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader across three parameter sets (default, 8-deep banks, 3 banks).
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rdy [3];
  logic [15:0] ins [3];
  logic        rel [3];

  logic wr0, wr1, wr2, valid0, valid1, valid2, busy0, busy1, busy2;
  logic drop0, drop1, drop2, ovf0, ovf1, ovf2;
  logic [0:0]  bank0, bank1, ab0, ab1;
  logic [1:0]  bank2, ab2;
  logic [10:0] addr0, addr2;
  logic [2:0]  addr1;
  logic [15:0] instr0, instr1, instr2;
  logic [11:0] len0, len2;
  logic [3:0]  len1;

  program_loader u_dut0 (
    .clock_in(clk), .reset_n_in(rst_n), .ready_in(rdy[0]), .instruction_in(ins[0]),
    .bank_release_in(rel[0]), .memory_wr_out(wr0), .memory_bank_out(bank0),
    .memory_address_out(addr0), .instruction_out(instr0), .active_bank_out(ab0),
    .active_length_out(len0), .program_valid_out(valid0), .busy_out(busy0),
    .drop_out(drop0), .overflow_out(ovf0));

  program_loader #(.ADDRESS_WIDTH(3)) u_dut1 (
    .clock_in(clk), .reset_n_in(rst_n), .ready_in(rdy[1]), .instruction_in(ins[1]),
    .bank_release_in(rel[1]), .memory_wr_out(wr1), .memory_bank_out(bank1),
    .memory_address_out(addr1), .instruction_out(instr1), .active_bank_out(ab1),
    .active_length_out(len1), .program_valid_out(valid1), .busy_out(busy1),
    .drop_out(drop1), .overflow_out(ovf1));

  program_loader #(.NUM_BANKS(3)) u_dut2 (
    .clock_in(clk), .reset_n_in(rst_n), .ready_in(rdy[2]), .instruction_in(ins[2]),
    .bank_release_in(rel[2]), .memory_wr_out(wr2), .memory_bank_out(bank2),
    .memory_address_out(addr2), .instruction_out(instr2), .active_bank_out(ab2),
    .active_length_out(len2), .program_valid_out(valid2), .busy_out(busy2),
    .drop_out(drop2), .overflow_out(ovf2));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of each loader, driven from the stimulus side.
  int nb    [3] = '{2, 2, 3};
  int depth [3] = '{2048, 8, 2048};
  int m_wb [3], m_ptr [3], m_cnt [3], m_rb [3];
  int m_len [3][8];

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  // Event code: {drop, overflow, bank, address, data}.
  function automatic logic [31:0] enc(input int kind, input int bank, input int addr, input int data);
    return {2'(kind), 3'(bank), 11'(addr), 16'(data)};
  endfunction

  function automatic void sb_push(input int d, input logic [31:0] v);
    case (d)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  task automatic sb_pop(input int d, output int n, output logic [31:0] v);
    v = '0;
    case (d)
      0:       begin n = q0.size(); if (n > 0) v = q0.pop_front(); end
      1:       begin n = q1.size(); if (n > 0) v = q1.pop_front(); end
      default: begin n = q2.size(); if (n > 0) v = q2.pop_front(); end
    endcase
  endtask

  function automatic int sb_size(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_wb[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0; m_rb[d] = 0;
      for (int b = 0; b < 8; b++) m_len[d][b] = 0;
    end
  endtask

  // Drive one cycle on loader d (called at a falling edge) and predict its effect.
  task automatic step(input int d, input logic r, input logic [15:0] w, input logic rl);
    bit rel_eff, last, term;
    rdy[d] = r; ins[d] = w; rel[d] = rl;
    rel_eff = rl && (m_cnt[d] > 0);
    if (r) begin
      if (m_cnt[d] == nb[d]) begin
        sb_push(d, enc(2, 0, 0, 0));
      end else begin
        last = (m_ptr[d] == depth[d] - 1);
        term = (w == 16'h0000);
        sb_push(d, enc((last && !term) ? 1 : 0, m_wb[d], m_ptr[d], int'(w)));
        if (term || last) begin
          m_len[d][m_wb[d]] = m_ptr[d] + 1;
          m_wb[d]  = (m_wb[d] + 1) % nb[d];
          m_ptr[d] = 0;
          m_cnt[d]++;
        end else begin
          m_ptr[d]++;
        end
      end
    end
    if (rel_eff) begin
      m_rb[d] = (m_rb[d] + 1) % nb[d];
      m_cnt[d]--;
    end
    @(negedge clk);
    rdy[d] = 1'b0; rel[d] = 1'b0;
  endtask

  task automatic send(input int d, input logic [15:0] w);
    step(d, 1'b1, w, 1'b0);
  endtask

  task automatic check_status(input int d);
    logic v, b;
    logic [31:0] a, l;
    case (d)
      0:       begin v = valid0; b = busy0; a = 32'(ab0); l = 32'(len0); end
      1:       begin v = valid1; b = busy1; a = 32'(ab1); l = 32'(len1); end
      default: begin v = valid2; b = busy2; a = 32'(ab2); l = 32'(len2); end
    endcase
    check_eq($sformatf("d%0d program_valid", d), 32'(v), 32'(m_cnt[d] > 0));
    check_eq($sformatf("d%0d busy", d), 32'(b), 32'(m_ptr[d] > 0));
    check_eq($sformatf("d%0d active_bank", d), a, 32'(m_rb[d]));
    if (m_cnt[d] > 0)
      check_eq($sformatf("d%0d active_length", d), l, 32'(m_len[d][m_rb[d]]));
  endtask

  // Scoreboard consumer: every write/drop/overflow must match the next predicted event.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic w, dr, ov;
      logic [2:0] b;
      logic [10:0] a;
      logic [15:0] dt;
      logic [31:0] obs, exp;
      int n;
      case (d)
        0:       begin w = wr0; dr = drop0; ov = ovf0; b = 3'(bank0); a = 11'(addr0); dt = instr0; end
        1:       begin w = wr1; dr = drop1; ov = ovf1; b = 3'(bank1); a = 11'(addr1); dt = instr1; end
        default: begin w = wr2; dr = drop2; ov = ovf2; b = 3'(bank2); a = 11'(addr2); dt = instr2; end
      endcase
      if (w || dr || ov) begin
        obs = {dr, ov, w ? b : 3'b0, w ? a : 11'b0, w ? dt : 16'b0};
        sb_pop(d, n, exp);
        if (n == 0) check_eq($sformatf("d%0d unexpected event 0x%0h", d, obs), 32'(n), 32'd1);
        else        check_eq($sformatf("d%0d event", d), obs, exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin rdy[d] = 1'b0; ins[d] = '0; rel[d] = 1'b0; end
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) check_status(d);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // First program and a full second program on the default loader, then a drop.
    send(0, 16'h0004); send(0, 16'h0003); send(0, 16'h0000);
    check_status(0);
    for (int i = 10; i <= 15; i++) send(0, 16'(i));
    check_status(0);
    send(0, 16'h0000);
    check_status(0);
    send(0, 16'h0011);
    check_status(0);
    // Release together with a word while full: word dropped, release taken.
    step(0, 1'b1, 16'h0012, 1'b1);
    check_status(0);
    // Commit and release in the same cycle.
    send(0, 16'h0005);
    check_status(0);
    step(0, 1'b1, 16'h0000, 1'b1);
    check_status(0);
    send(0, 16'h0007);

    // Overflow on the 8-deep loader.
    for (int i = 0; i < 8; i++) send(1, 16'h0001);
    check_status(1);
    send(1, 16'h0001);
    check_status(1);

    // Three-bank wrap, including a release while nothing is committed.
    step(2, 1'b0, 16'h0000, 1'b1);
    check_status(2);
    for (int i = 0; i < 3; i++) send(2, 16'h0000);
    check_status(2);
    step(2, 1'b0, 16'h0000, 1'b1);
    send(2, 16'h0000);
    check_status(2);
    send(2, 16'h0009);
    check_status(2);

    // Reset mid-load: outputs clear at once and the next program restarts at bank 0.
    send(0, 16'h0008);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst memory_wr", 32'(wr0), 32'd0);
    check_eq("rst memory_address", 32'(addr0), 32'd0);
    check_eq("rst instruction", 32'(instr0), 32'd0);
    check_eq("rst active_length", 32'(len0), 32'd0);
    check_eq("rst program_valid", 32'(valid0), 32'd0);
    check_eq("rst busy", 32'(busy0), 32'd0);
    check_eq("rst active_bank", 32'(ab0), 32'd0);
    for (int d = 0; d < 3; d++) check_eq($sformatf("d%0d pending before reset", d), 32'(sb_size(d)), 32'd0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(0, 16'h0001); send(0, 16'h0000);
    check_status(0);

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_eq($sformatf("d%0d pending at end", d), 32'(sb_size(d)), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
